rs_unit: RTL and testbench
==========================

Name: rs_unit

Overview:
- Reservation station between the issue stage and the integer ALU.
- Holds RS-bound micro-ops from issue (ALU ops, branches, JALR, load/store address generation) until both operands are ready.
- Captures results broadcast on the CDBA/CDBD buses.
- Dispatches at most one ready entry per cycle to the ALU, tagged with its ROB name.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥4).
- ROBID_W, 4, ROB name width (matches `ROBID).
- OP_W, 6, internal opcode width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; low = freeze all state.
- clear  input  1  misprediction flush; synchronous.
- issue_sgn  input  1  new entry valid this cycle.
- issue_opcode  input  OP_W  operation code.
- issue_rs1_val  input  32  operand 1 value, or producer tag in [ROBID_W-1:0] if not ready.
- issue_rs1_rdy  input  1  operand 1 ready.
- issue_rs2_val  input  32  operand 2 value/tag.
- issue_rs2_rdy  input  1  operand 2 ready.
- issue_rob_name  input  ROBID_W  destination ROB name.
- rs_full  output  1  fewer than 2 free entries.
- cdba_sgn  input  1  ALU broadcast valid.
- cdba_result  input  32  ALU result.
- cdba_rob_name  input  ROBID_W  ALU result tag.
- cdbd_sgn  input  1  LSB broadcast valid.
- cdbd_result  input  32  LSB result.
- cdbd_rob_name  input  ROBID_W  LSB result tag.
- alu_sgn  output  1  dispatch valid (one-cycle pulse).
- alu_opcode  output  OP_W  dispatched opcode.
- alu_a  output  32  operand 1.
- alu_b  output  32  operand 2.
- alu_rob_name  output  ROBID_W  dispatched ROB name.
- overflow_err  output  1  sticky; issue attempted with no free entry.

Behaviour:
- Reset (rst=0, async):
  - All busy flags cleared.
  - alu_sgn=0, alu_opcode=0, alu_a=0, alu_b=0, alu_rob_name=0, overflow_err=0.
  - rs_full=0 follows directly.
- Per-entry state: busy, opcode, v1, r1, v2, r2, rob_name. When rN=0, vN[ROBID_W-1:0] is the awaited tag.
- rs_full:
  - Combinational from registered busy flags only (no input dependency).
  - High when free entries ≤1, leaving room for the one instruction already in flight in the issue pipeline.
- rdy=0: no state changes; alu_sgn forced 0 at that edge; other outputs hold.
- clear=1 (with rdy=1):
  - All busy cleared; alu_sgn←0; overflow_err unchanged.
  - Has priority over issue, wakeup and dispatch in the same cycle.
- Allocation:
  - On an edge with issue_sgn=1, the entry goes to the lowest-index non-busy slot.
  - A slot freed by dispatch at the same edge is not reused until the next cycle.
  - With no free slot, the issue is dropped and overflow_err←1.
- Wakeup:
  - Every busy entry with rN=0 whose tag equals cdba_rob_name (cdba_sgn=1) or cdbd_rob_name (cdbd_sgn=1) latches that result and sets rN=1.
  - If both buses match the same tag, CDBA wins.
  - Wakeup applies identically to the operands of an entry being allocated in the same cycle (forwarding into the new slot).
- Dispatch:
  - Selects the lowest-index entry with busy=1, r1=1, r2=1, evaluated on registered state.
  - An entry woken at edge N is eligible to dispatch at edge N+1 at the earliest.
  - At the dispatch edge, alu_* are loaded from the entry, alu_sgn←1 and the entry's busy←0.
  - If nothing is eligible, alu_sgn←0 and the other alu_* outputs hold.
- Latency:
  - Issue with both operands ready → alu_sgn high one cycle after the allocation edge (best case).
  - Issue → CDB wakeup → dispatch adds one further cycle after the broadcast.
- Tag compare uses only [ROBID_W-1:0]; upper bits of a not-ready vN are don't-care.
- One allocation and one dispatch per cycle may occur simultaneously; occupancy changes by +1, 0 or −1.

Test Plan:
- Reset: drive rst=0 mid-run with 5 busy entries → all alu_* = 0 and rs_full=0 immediately; after release, an issue of ADD (a=3, b=4, tag 2) gives alu_sgn pulse 1 cycle later with a=3, b=4, rob_name=2.
- Wakeup: issue entry with r1=0 tag 5, b=10 ready; 3 cycles later cdbd_sgn=1, rob_name=5, result=0x77 → next cycle alu_a=0x77, alu_b=10. Same-tag dual broadcast (CDBA=0x11, CDBD=0x22) → alu_a=0x11.
- Same-cycle forward: issue with r2=0 tag 7 while cdba_sgn=1, tag 7, result=0xABCD → entry dispatches next cycle with alu_b=0xABCD.
- Fill: issue 15 non-ready entries into RS_SIZE=16 → rs_full=1; 16th accepted; 17th sets overflow_err=1 and is not dispatched.
- Ordering: make entries 3 and 9 ready in the same cycle → entry 3 dispatched first, entry 9 the following cycle; alu_sgn high for exactly two cycles.
- Flush/freeze: clear=1 with 6 ready entries → no dispatch afterward, rs_full=0. With rdy=0 for 4 cycles during a CDB broadcast → no wakeup, and alu_sgn stays 0.

Source files
------------

// File: rtl/rs_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_unit_if
// Description : Bundle of the reservation-station side signals: global
//               ready/flush, the issue port, the two result broadcast buses
//               (CDBA from the ALU, CDBD from the load/store buffer) and the
//               ALU dispatch port.
//   master : issue-stage / environment side (drives issue, CDBs, rdy, clear)
//   slave  : reservation station (drives rs_full, alu_*, overflow_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_unit_if #(
  parameter int ROBID_W = 4,
  parameter int OP_W    = 6
);
  logic               rdy;
  logic               clear;

  logic               issue_sgn;
  logic [OP_W-1:0]    issue_opcode;
  logic [31:0]        issue_rs1_val;
  logic               issue_rs1_rdy;
  logic [31:0]        issue_rs2_val;
  logic               issue_rs2_rdy;
  logic [ROBID_W-1:0] issue_rob_name;
  logic               rs_full;

  logic               cdba_sgn;
  logic [31:0]        cdba_result;
  logic [ROBID_W-1:0] cdba_rob_name;
  logic               cdbd_sgn;
  logic [31:0]        cdbd_result;
  logic [ROBID_W-1:0] cdbd_rob_name;

  logic               alu_sgn;
  logic [OP_W-1:0]    alu_opcode;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [ROBID_W-1:0] alu_rob_name;
  logic               overflow_err;

  modport master (
    output rdy, clear,
    output issue_sgn, issue_opcode, issue_rs1_val, issue_rs1_rdy,
    output issue_rs2_val, issue_rs2_rdy, issue_rob_name,
    output cdba_sgn, cdba_result, cdba_rob_name,
    output cdbd_sgn, cdbd_result, cdbd_rob_name,
    input  rs_full, alu_sgn, alu_opcode, alu_a, alu_b, alu_rob_name,
    input  overflow_err
  );

  modport slave (
    input  rdy, clear,
    input  issue_sgn, issue_opcode, issue_rs1_val, issue_rs1_rdy,
    input  issue_rs2_val, issue_rs2_rdy, issue_rob_name,
    input  cdba_sgn, cdba_result, cdba_rob_name,
    input  cdbd_sgn, cdbd_result, cdbd_rob_name,
    output rs_full, alu_sgn, alu_opcode, alu_a, alu_b, alu_rob_name,
    output overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/rs_unit.sv
`default_nettype none
// ============================================================================
// Module      : rs_unit
// Description : Reservation station between issue and the integer ALU. Holds
//               micro-ops until both operands are known, snoops the CDBA/CDBD
//               result buses, and dispatches the lowest-index ready entry
//               (at most one per cycle) to the ALU.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : rs_unit_if.slave - rdy/clear, issue port, CDBA/CDBD, ALU port,
//          rs_full and sticky overflow_err
// Revision    : 1.0 - initial release
// ============================================================================
module rs_unit #(
  parameter int RS_SIZE = 16,
  parameter int ROBID_W = 4,
  parameter int OP_W    = 6
) (
  input  logic     clk,
  input  logic     rst,
  rs_unit_if.slave bus
);
  localparam int c_IDX_W = $clog2(RS_SIZE);
  localparam int c_CNT_W = c_IDX_W + 1;

  // Per-entry state. When r_rN is low, r_vN[ROBID_W-1:0] holds the awaited tag.
  logic               r_busy [RS_SIZE];
  logic [OP_W-1:0]    r_op   [RS_SIZE];
  logic [31:0]        r_v1   [RS_SIZE];
  logic               r_r1   [RS_SIZE];
  logic [31:0]        r_v2   [RS_SIZE];
  logic               r_r2   [RS_SIZE];
  logic [ROBID_W-1:0] r_rob  [RS_SIZE];

  logic               r_alu_sgn;
  logic [OP_W-1:0]    r_alu_op;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [ROBID_W-1:0] r_alu_rob;
  logic               r_ovf;

  // {ready, value} of each operand after snooping this cycle's broadcasts.
  logic [32:0]        w_op1_nxt [RS_SIZE];
  logic [32:0]        w_op2_nxt [RS_SIZE];
  logic [32:0]        w_new_op1;
  logic [32:0]        w_new_op2;

  logic               w_alloc_found;
  logic [c_IDX_W-1:0] w_alloc_idx;
  logic               w_disp_found;
  logic [c_IDX_W-1:0] w_disp_idx;
  logic [c_CNT_W-1:0] w_free_cnt;

  // Operand capture from the result buses; CDBA wins when both carry the tag.
  function automatic logic [32:0] f_snoop(
    input logic               rdy_in,
    input logic [31:0]        val,
    input logic               a_sgn,
    input logic [ROBID_W-1:0] a_tag,
    input logic [31:0]        a_res,
    input logic               d_sgn,
    input logic [ROBID_W-1:0] d_tag,
    input logic [31:0]        d_res
  );
    logic [32:0] res;
    res = {rdy_in, val};
    if (!rdy_in) begin
      if (a_sgn && (a_tag == val[ROBID_W-1:0])) begin
        res = {1'b1, a_res};
      end else if (d_sgn && (d_tag == val[ROBID_W-1:0])) begin
        res = {1'b1, d_res};
      end
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_wake
    assign w_op1_nxt[gi] = f_snoop(r_r1[gi], r_v1[gi],
                                   bus.cdba_sgn, bus.cdba_rob_name, bus.cdba_result,
                                   bus.cdbd_sgn, bus.cdbd_rob_name, bus.cdbd_result);
    assign w_op2_nxt[gi] = f_snoop(r_r2[gi], r_v2[gi],
                                   bus.cdba_sgn, bus.cdba_rob_name, bus.cdba_result,
                                   bus.cdbd_sgn, bus.cdbd_rob_name, bus.cdbd_result);
  end

  // A newly issued op snoops the same broadcasts so it is not missed.
  assign w_new_op1 = f_snoop(bus.issue_rs1_rdy, bus.issue_rs1_val,
                             bus.cdba_sgn, bus.cdba_rob_name, bus.cdba_result,
                             bus.cdbd_sgn, bus.cdbd_rob_name, bus.cdbd_result);
  assign w_new_op2 = f_snoop(bus.issue_rs2_rdy, bus.issue_rs2_val,
                             bus.cdba_sgn, bus.cdba_rob_name, bus.cdba_result,
                             bus.cdbd_sgn, bus.cdbd_rob_name, bus.cdbd_result);

  // Priority pickers scan downward so the lowest index is the last writer.
  // Both look only at registered state, so a slot freed by dispatch is not
  // reallocated on the same edge and a freshly woken entry waits one cycle.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    w_disp_found  = 1'b0;
    w_disp_idx    = '0;
    w_free_cnt    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = c_IDX_W'(i);
        w_free_cnt    = w_free_cnt + c_CNT_W'(1);
      end
      if (r_busy[i] && r_r1[i] && r_r2[i]) begin
        w_disp_found = 1'b1;
        w_disp_idx   = c_IDX_W'(i);
      end
    end
  end

  // One slot of headroom is kept for the op already in the issue pipeline.
  assign bus.rs_full = (w_free_cnt <= c_CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i] <= 1'b0;
        r_op[i]   <= '0;
        r_v1[i]   <= '0;
        r_r1[i]   <= 1'b0;
        r_v2[i]   <= '0;
        r_r2[i]   <= 1'b0;
        r_rob[i]  <= '0;
      end
      r_alu_sgn <= 1'b0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_rob <= '0;
      r_ovf     <= 1'b0;
    end else if (!bus.rdy) begin
      r_alu_sgn <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i] <= 1'b0;
      end
      r_alu_sgn <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          {r_r1[i], r_v1[i]} <= w_op1_nxt[i];
          {r_r2[i], r_v2[i]} <= w_op2_nxt[i];
        end
      end

      if (w_disp_found) begin
        r_busy[w_disp_idx] <= 1'b0;
        r_alu_sgn          <= 1'b1;
        r_alu_op           <= r_op[w_disp_idx];
        r_alu_a            <= r_v1[w_disp_idx];
        r_alu_b            <= r_v2[w_disp_idx];
        r_alu_rob          <= r_rob[w_disp_idx];
      end else begin
        r_alu_sgn <= 1'b0;
      end

      // The allocated slot is never busy, so it cannot collide with the
      // wakeup or dispatch writes above.
      if (bus.issue_sgn) begin
        if (w_alloc_found) begin
          r_busy[w_alloc_idx]                     <= 1'b1;
          r_op[w_alloc_idx]                       <= bus.issue_opcode;
          r_rob[w_alloc_idx]                      <= bus.issue_rob_name;
          {r_r1[w_alloc_idx], r_v1[w_alloc_idx]} <= w_new_op1;
          {r_r2[w_alloc_idx], r_v2[w_alloc_idx]} <= w_new_op2;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.alu_sgn      = r_alu_sgn;
  assign bus.alu_opcode   = r_alu_op;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_rob_name = r_alu_rob;
  assign bus.overflow_err = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_rs_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_unit
// Description : Self-checking bench for rs_unit. A behavioural model of the
//               station (list of entries, lowest-free allocation, lowest-ready
//               dispatch, bus snooping) predicts every output each cycle;
//               directed steps add fixed expected values for key scenarios,
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_unit;
  localparam int RS_SIZE = 16;
  localparam int ROBID_W = 4;
  localparam int OP_W    = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rs_unit_if #(.ROBID_W(ROBID_W), .OP_W(OP_W)) bus ();

  rs_unit #(.RS_SIZE(RS_SIZE), .ROBID_W(ROBID_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit                 busy;
    logic [OP_W-1:0]    op;
    logic [31:0]        a;
    logic [31:0]        b;
    bit                 ra;
    bit                 rb;
    logic [ROBID_W-1:0] rob;
  } ent_t;

  ent_t               m [RS_SIZE];
  bit                 e_sgn;
  logic [OP_W-1:0]    e_op;
  logic [31:0]        e_a;
  logic [31:0]        e_b;
  logic [ROBID_W-1:0] e_rob;
  bit                 e_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [32:0] snoop(input bit r, input logic [31:0] v);
    if (r) return {1'b1, v};
    if (bus.cdba_sgn && bus.cdba_rob_name == v[ROBID_W-1:0]) return {1'b1, bus.cdba_result};
    if (bus.cdbd_sgn && bus.cdbd_rob_name == v[ROBID_W-1:0]) return {1'b1, bus.cdbd_result};
    return {1'b0, v};
  endfunction

  function automatic bit exp_full();
    int nfree = 0;
    for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) nfree++;
    return (nfree <= 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
    e_sgn = 0; e_op = '0; e_a = '0; e_b = '0; e_rob = '0; e_ovf = 0;
  endtask

  // Apply the station's rules for one clock edge using current inputs.
  task automatic model_edge();
    int d = -1;
    int f = -1;
    bit [32:0] t;
    if (!bus.rdy) begin e_sgn = 0; return; end
    if (bus.clear) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
      e_sgn = 0;
      return;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (d < 0 && m[i].busy && m[i].ra && m[i].rb) d = i;
      if (f < 0 && !m[i].busy) f = i;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].busy) begin
        t = snoop(m[i].ra, m[i].a); {m[i].ra, m[i].a} = t;
        t = snoop(m[i].rb, m[i].b); {m[i].rb, m[i].b} = t;
      end
    end
    if (d >= 0) begin
      e_sgn = 1; e_op = m[d].op; e_a = m[d].a; e_b = m[d].b; e_rob = m[d].rob;
      m[d].busy = 0;
    end else begin
      e_sgn = 0;
    end
    if (bus.issue_sgn) begin
      if (f >= 0) begin
        m[f].busy = 1;
        m[f].op   = bus.issue_opcode;
        m[f].rob  = bus.issue_rob_name;
        t = snoop(bus.issue_rs1_rdy, bus.issue_rs1_val); {m[f].ra, m[f].a} = t;
        t = snoop(bus.issue_rs2_rdy, bus.issue_rs2_val); {m[f].rb, m[f].b} = t;
      end else begin
        e_ovf = 1;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("alu_sgn",      32'(bus.alu_sgn),      32'(e_sgn));
    chk("alu_opcode",   32'(bus.alu_opcode),   32'(e_op));
    chk("alu_a",        bus.alu_a,             e_a);
    chk("alu_b",        bus.alu_b,             e_b);
    chk("alu_rob_name", 32'(bus.alu_rob_name), 32'(e_rob));
    chk("rs_full",      32'(bus.rs_full),      32'(exp_full()));
    chk("overflow_err", 32'(bus.overflow_err), 32'(e_ovf));
    bus.issue_sgn = 0; bus.cdba_sgn = 0; bus.cdbd_sgn = 0; bus.clear = 0;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] v1, input bit r1,
                       input logic [31:0] v2, input bit r2, input logic [ROBID_W-1:0] rob);
    bus.issue_sgn = 1; bus.issue_opcode = op;
    bus.issue_rs1_val = v1; bus.issue_rs1_rdy = r1;
    bus.issue_rs2_val = v2; bus.issue_rs2_rdy = r2;
    bus.issue_rob_name = rob;
  endtask

  task automatic cdba(input logic [ROBID_W-1:0] tag, input logic [31:0] res);
    bus.cdba_sgn = 1; bus.cdba_rob_name = tag; bus.cdba_result = res;
  endtask

  task automatic cdbd(input logic [ROBID_W-1:0] tag, input logic [31:0] res);
    bus.cdbd_sgn = 1; bus.cdbd_rob_name = tag; bus.cdbd_result = res;
  endtask

  initial begin
    bus.rdy = 1; bus.clear = 0;
    bus.issue_sgn = 0; bus.issue_opcode = '0; bus.issue_rs1_val = '0; bus.issue_rs1_rdy = 0;
    bus.issue_rs2_val = '0; bus.issue_rs2_rdy = 0; bus.issue_rob_name = '0;
    bus.cdba_sgn = 0; bus.cdba_result = '0; bus.cdba_rob_name = '0;
    bus.cdbd_sgn = 0; bus.cdbd_result = '0; bus.cdbd_rob_name = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sgn",  32'(bus.alu_sgn), 0);
    chk("rst_a",    bus.alu_a, 0);
    chk("rst_full", 32'(bus.rs_full), 0);
    chk("rst_ovf",  32'(bus.overflow_err), 0);
    rst = 1;

    // Mid-run asynchronous reset with a dispatched op and 5 busy entries
    issue(6'd9, 32'h55, 1, 32'h66, 1, 4'd9); cyc();
    for (int i = 0; i < 5; i++) begin issue(6'd1, 32'd12, 0, 32'd1, 1, 4'(i)); cyc(); end
    chk("pre_rst_a", bus.alu_a, 32'h55);
    #2 rst = 0;
    model_reset();
    #1;
    chk("arst_sgn",  32'(bus.alu_sgn), 0);
    chk("arst_op",   32'(bus.alu_opcode), 0);
    chk("arst_a",    bus.alu_a, 0);
    chk("arst_b",    bus.alu_b, 0);
    chk("arst_rob",  32'(bus.alu_rob_name), 0);
    chk("arst_full", 32'(bus.rs_full), 0);
    @(posedge clk); #1;
    rst = 1;

    // Best-case latency: ADD a=3 b=4 tag 2
    issue(6'd1, 32'd3, 1, 32'd4, 1, 4'd2); cyc();
    chk("lat_early", 32'(bus.alu_sgn), 0);
    cyc();
    chk("lat_sgn", 32'(bus.alu_sgn), 1);
    chk("lat_a",   bus.alu_a, 32'd3);
    chk("lat_b",   bus.alu_b, 32'd4);
    chk("lat_rob", 32'(bus.alu_rob_name), 32'd2);
    cyc();
    chk("lat_pulse", 32'(bus.alu_sgn), 0);

    // Wakeup via CDBD
    issue(6'd2, 32'hFFFF_FFF5, 0, 32'd10, 1, 4'd3); cyc();
    cyc(); cyc();
    cdbd(4'd5, 32'h77); cyc();
    chk("wake_wait", 32'(bus.alu_sgn), 0);
    cyc();
    chk("wake_sgn", 32'(bus.alu_sgn), 1);
    chk("wake_a",   bus.alu_a, 32'h77);
    chk("wake_b",   bus.alu_b, 32'd10);

    // Same tag on both buses: CDBA wins
    issue(6'd3, 32'd6, 0, 32'd1, 1, 4'd4); cyc();
    cdba(4'd6, 32'h11); cdbd(4'd6, 32'h22); cyc();
    cyc();
    chk("dual_a", bus.alu_a, 32'h11);

    // Forwarding into the slot being allocated
    issue(6'd4, 32'd1, 1, 32'd7, 0, 4'd5); cdba(4'd7, 32'hABCD); cyc();
    cyc();
    chk("fwd_sgn", 32'(bus.alu_sgn), 1);
    chk("fwd_b",   bus.alu_b, 32'hABCD);

    // rdy low forces alu_sgn to 0 even with a ready entry
    issue(6'd5, 32'd8, 1, 32'd9, 1, 4'd6); cyc();
    bus.rdy = 0; cyc();
    chk("frz_sgn", 32'(bus.alu_sgn), 0);
    bus.rdy = 1; cyc();
    chk("unfrz_sgn", 32'(bus.alu_sgn), 1);
    chk("unfrz_rob", 32'(bus.alu_rob_name), 32'd6);
    cyc();

    // Fill
    for (int i = 0; i < 15; i++) begin issue(6'd7, 32'd15, 0, 32'd1, 1, 4'(i)); cyc(); end
    chk("fill_full", 32'(bus.rs_full), 1);
    issue(6'd7, 32'd15, 0, 32'd1, 1, 4'd15); cyc();
    chk("fill16_ovf", 32'(bus.overflow_err), 0);
    issue(6'd8, 32'd1, 1, 32'd2, 1, 4'd1); cyc();
    chk("fill17_ovf", 32'(bus.overflow_err), 1);
    cyc();
    chk("fill17_nodisp", 32'(bus.alu_sgn), 0);
    bus.clear = 1; cyc();
    chk("clr_full", 32'(bus.rs_full), 0);

    // Ordering: entries 3 and 9 woken together
    for (int i = 0; i < 10; i++) begin
      issue(6'd10, (i == 3 || i == 9) ? 32'd8 : 32'd12, 0, 32'd0, 1, 4'(i)); cyc();
    end
    cdba(4'd8, 32'h99); cyc();
    cyc();
    chk("ord_sgn0", 32'(bus.alu_sgn), 1);
    chk("ord_rob0", 32'(bus.alu_rob_name), 32'd3);
    cyc();
    chk("ord_sgn1", 32'(bus.alu_sgn), 1);
    chk("ord_rob1", 32'(bus.alu_rob_name), 32'd9);
    cyc();
    chk("ord_end", 32'(bus.alu_sgn), 0);
    bus.clear = 1; cyc();

    // Flush with 6 ready entries
    for (int i = 0; i < 6; i++) begin issue(6'd11, 32'd13, 0, 32'd3, 1, 4'(i)); cyc(); end
    cdbd(4'd13, 32'h42); cyc();
    bus.clear = 1; cyc();
    chk("flush_sgn", 32'(bus.alu_sgn), 0);
    cyc(); cyc();
    chk("flush_after", 32'(bus.alu_sgn), 0);
    chk("flush_full",  32'(bus.rs_full), 0);

    // Freeze during a broadcast: no wakeup
    issue(6'd12, 32'd14, 0, 32'd5, 1, 4'd7); cyc();
    bus.rdy = 0;
    for (int i = 0; i < 4; i++) begin
      cdba(4'd14, 32'h5A); cyc();
      chk("frz_nodisp", 32'(bus.alu_sgn), 0);
    end
    bus.rdy = 1; cyc(); cyc();
    chk("frz_nowake", 32'(bus.alu_sgn), 0);
    cdba(4'd14, 32'h5A); cyc(); cyc();
    chk("frz_late_sgn", 32'(bus.alu_sgn), 1);
    chk("frz_late_a",   bus.alu_a, 32'h5A);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.rdy = ($urandom_range(0, 9) != 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(OP_W'($urandom), $urandom, $urandom_range(0, 2) == 0,
              $urandom, $urandom_range(0, 2) == 0, ROBID_W'($urandom));
      if ($urandom_range(0, 2) == 0) cdba(ROBID_W'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) cdbd(ROBID_W'($urandom), $urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
